// File: rtl/uart_tx_frame_arbiter_if.sv
// Handshake bundle between the two frame requesters, the UART TX serializer and the frame arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface uart_tx_frame_arbiter_if;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_last;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_last;
   logic       req1_ready;
   logic       uart_cts_n;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic [1:0] grant;
   logic       frame_done;
   logic       wdt_error;

   modport master (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  uart_cts_n, tx_busy,
      output req0_ready, req1_ready,
      output tx_start, tx_data, grant, frame_done, wdt_error
   );

   modport slave (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output uart_cts_n, tx_busy,
      input  req0_ready, req1_ready,
      input  tx_start, tx_data, grant, frame_done, wdt_error
   );
endinterface

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin whole-frame arbiter feeding one UART byte transmitter; stall watchdog built with UART_TX_FRAME_ARBITER_WDT_EN.
// Accept-to-tx_start latency 1 cycle; only the frame owner sees ready, and only in ISSUE with CTS low.
module uart_tx_frame_arbiter #(
   parameter int BYTE_GAP_CYCLES  = 100,
   parameter int FRAME_GAP_CYCLES = 1000,
   parameter int WDT_CYCLES       = 17360
) (
   input logic                     clk,
   input logic                     rst_n,
   uart_tx_frame_arbiter_if.master bus
);
   localparam int MAX_GF  = (BYTE_GAP_CYCLES > FRAME_GAP_CYCLES) ? BYTE_GAP_CYCLES : FRAME_GAP_CYCLES;
   localparam int MAX_ALL = (MAX_GF > WDT_CYCLES) ? MAX_GF : WDT_CYCLES;
   localparam int CNT_W   = (MAX_ALL > 0) ? $clog2(MAX_ALL + 1) : 1;

   // Gaps load N-1 so the gap state lasts exactly N cycles, leaving on count zero.
   localparam logic [CNT_W-1:0] BG_LOAD = (BYTE_GAP_CYCLES > 0) ? CNT_W'(BYTE_GAP_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] FG_LOAD = (FRAME_GAP_CYCLES > 0) ? CNT_W'(FRAME_GAP_CYCLES - 1) : '0;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_BYTE_GAP  = 3'd4;
   localparam logic [2:0] S_FRAME_GAP = 3'd5;

   logic [2:0]       state;
   logic [1:0]       grant_q;
   logic             tx_start_q;
   logic [7:0]       tx_data_q;
   logic             last_flag;
   logic             last_served;
   logic [CNT_W-1:0] cnt;

   logic       owner_valid;
   logic [7:0] owner_data;
   logic       owner_last;
   logic       accept;
   logic       busy_fell;
   logic       wdt_fire;

   assign owner_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
   assign owner_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
   assign owner_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;
   assign accept      = (state == S_ISSUE) && owner_valid && !bus.uart_cts_n;
   assign busy_fell   = (state == S_WAIT_DONE) && !bus.tx_busy;

`ifdef UART_TX_FRAME_ARBITER_WDT_EN
   // A byte that completes on the expiry cycle is not aborted.
   assign wdt_fire = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) && (cnt == '0) && !busy_fell;
`else
   assign wdt_fire = 1'b0;
`endif

   assign bus.req0_ready = accept && grant_q[0];
   assign bus.req1_ready = accept && grant_q[1];
   assign bus.tx_start   = tx_start_q;
   assign bus.tx_data    = tx_data_q;
   assign bus.grant      = grant_q;
   assign bus.wdt_error  = wdt_fire;
   assign bus.frame_done = ((state == S_FRAME_GAP) && (cnt == '0)) ||
                           ((FRAME_GAP_CYCLES == 0) && busy_fell && last_flag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         grant_q     <= 2'b00;
         tx_start_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         last_flag   <= 1'b0;
         last_served <= 1'b1;
         cnt         <= '0;
      end else begin
         tx_start_q <= 1'b0;
         if (cnt != '0) cnt <= cnt - CNT_W'(1);

         if (wdt_fire) begin
            last_served <= grant_q[1];
            grant_q     <= 2'b00;
            state       <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.req0_valid || bus.req1_valid) begin
                     // last_served=1 means req1 went last, so req0 wins a tie.
                     if (bus.req0_valid && (!bus.req1_valid || last_served)) grant_q <= 2'b01;
                     else                                                     grant_q <= 2'b10;
                     state <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (accept) begin
                     tx_data_q  <= owner_data;
                     last_flag  <= owner_last;
                     tx_start_q <= 1'b1;
`ifdef UART_TX_FRAME_ARBITER_WDT_EN
                     cnt        <= CNT_W'(WDT_CYCLES);
`endif
                     state      <= S_WAIT_BUSY;
                  end
               end
               S_WAIT_BUSY: begin
                  if (bus.tx_busy) state <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (!bus.tx_busy) begin
                     if (last_flag) begin
                        if (FRAME_GAP_CYCLES == 0) begin
                           last_served <= grant_q[1];
                           grant_q     <= 2'b00;
                           state       <= S_IDLE;
                        end else begin
                           cnt   <= FG_LOAD;
                           state <= S_FRAME_GAP;
                        end
                     end else if (BYTE_GAP_CYCLES == 0) begin
                        state <= S_ISSUE;
                     end else begin
                        cnt   <= BG_LOAD;
                        state <= S_BYTE_GAP;
                     end
                  end
               end
               S_BYTE_GAP: begin
                  if (cnt == '0) state <= S_ISSUE;
               end
               S_FRAME_GAP: begin
                  if (cnt == '0) begin
                     last_served <= grant_q[1];
                     grant_q     <= 2'b00;
                     state       <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter with shortened gaps and a fixed-length transmitter model.
// Watchdog expectations follow UART_TX_FRAME_ARBITER_WDT_EN.
module tb_uart_tx_frame_arbiter;
   localparam int BG  = 4;
   localparam int FG  = 8;
   localparam int WDT = 40;
   localparam int BL  = 6;                   // transmitter busy cycles per byte
   localparam int D_IN_FRAME  = BL + BG + 3; // tx_start to tx_start within a frame
   localparam int D_FRAME_END = BL + 1 + FG; // last tx_start to frame_done
   localparam int D_NEW_FRAME = D_FRAME_END + 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_frame_arbiter_if bus ();

   uart_tx_frame_arbiter #(
      .BYTE_GAP_CYCLES (BG),
      .FRAME_GAP_CYCLES(FG),
      .WDT_CYCLES      (WDT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic       src;
      logic [7:0] data;
      logic       last;
      logic [1:0] exp_gnt;
      int         exp_delta;
   } vec_t;

   vec_t tbl[8];

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int st_cyc[$];
   logic [7:0] st_dat[$];
   logic [1:0] st_gnt[$];
   int fd_cyc[$];
   int wdt_cyc[$];
   int rdy0_seen = 0;
   int rdy1_seen = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic hold0 = 1'b0;
   logic stuck = 1'b0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.tx_start === 1'b1) begin
         st_cyc.push_back(cyc);
         st_dat.push_back(bus.tx_data);
         st_gnt.push_back(bus.grant);
      end
      if (bus.frame_done === 1'b1) fd_cyc.push_back(cyc);
      if (bus.wdt_error === 1'b1)  wdt_cyc.push_back(cyc);
      if (bus.req0_ready === 1'b1) rdy0_seen++;
      if (bus.req1_ready === 1'b1) rdy1_seen++;
   end

   // Requester sources: pop the head byte after a cycle in which ready was seen.
   initial begin
      logic acc0, acc1;
      bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
      bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
      forever begin
         @(negedge clk);
         acc0 = bus.req0_ready;
         acc1 = bus.req1_ready;
         @(posedge clk);
         #2;
         if (acc0 && q0.size() > 0) void'(q0.pop_front());
         if (acc1 && q1.size() > 0) void'(q1.pop_front());
         bus.req0_valid = (q0.size() > 0) && !hold0;
         bus.req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
         bus.req0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
         bus.req1_valid = (q1.size() > 0);
         bus.req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
         bus.req1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
      end
   end

   // Transmitter: busy from the cycle after tx_start for BL cycles, longer while stuck.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            @(posedge clk);
            #1 bus.tx_busy = 1'b1;
            repeat (BL) @(posedge clk);
            while (stuck) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   task automatic wait_idle(input string nm);
      for (int k = 0; k < 300 && (bus.grant !== 2'b00 || bus.tx_busy !== 1'b0); k++) @(posedge clk);
      #1;
      chk(nm, {bus.grant, bus.tx_busy}, 3'b000);
   endtask

   task automatic wait_starts(input int n, input string nm);
      for (int k = 0; k < 600 && st_cyc.size() < n; k++) @(posedge clk);
      #1;
      chk(nm, (st_cyc.size() >= n), 1);
   endtask

   initial begin
      int base, fdb, t0, prev, fdk, r0, r1, s;

      tbl[0] = '{1'b0, 8'hA5, 1'b0, 2'b01, 2};
      tbl[1] = '{1'b0, 8'h5A, 1'b0, 2'b01, D_IN_FRAME};
      tbl[2] = '{1'b0, 8'hFF, 1'b1, 2'b01, D_IN_FRAME};
      tbl[3] = '{1'b1, 8'h12, 1'b0, 2'b10, D_NEW_FRAME};
      tbl[4] = '{1'b1, 8'h34, 1'b1, 2'b10, D_IN_FRAME};
      tbl[5] = '{1'b0, 8'h0F, 1'b1, 2'b01, D_NEW_FRAME};
      tbl[6] = '{1'b1, 8'h7E, 1'b1, 2'b10, D_NEW_FRAME};
      tbl[7] = '{1'b0, 8'hC3, 1'b1, 2'b01, D_NEW_FRAME};

      rst_n = 1'b0;
      bus.uart_cts_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", bus.grant, 2'b00);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_frame_done", bus.frame_done, 1'b0);
      chk("rst_wdt_error", bus.wdt_error, 1'b0);
      chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frames A5 5A FF / 12 34 loaded together, then ties that must alternate.
      base = st_cyc.size();
      fdb  = fd_cyc.size();
      t0   = cyc;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].src) q1.push_back({tbl[i].last, tbl[i].data});
         else            q0.push_back({tbl[i].last, tbl[i].data});
      end
      wait_starts(base + 8, "tbl_all_started");
      for (int k = 0; k < 200 && fd_cyc.size() < fdb + 5; k++) @(posedge clk);
      #1;
      chk("tbl_frame_done_count", fd_cyc.size() - fdb, 5);
      chk("tbl_grant_idle", bus.grant, 2'b00);
      prev = t0;
      fdk  = fdb;
      for (int i = 0; i < 8; i++) begin
         if (base + i < st_cyc.size()) begin
            chk($sformatf("tbl%0d_data", i), st_dat[base + i], tbl[i].data);
            chk($sformatf("tbl%0d_grant", i), st_gnt[base + i], tbl[i].exp_gnt);
            chk($sformatf("tbl%0d_delta", i), st_cyc[base + i] - prev, tbl[i].exp_delta);
            prev = st_cyc[base + i];
            if (tbl[i].last) begin
               if (fdk < fd_cyc.size())
                  chk($sformatf("tbl%0d_frame_done", i), fd_cyc[fdk] - prev, D_FRAME_END);
               else
                  chk($sformatf("tbl%0d_frame_done", i), 0, 1);
               fdk++;
            end
         end else begin
            chk($sformatf("tbl%0d_missing", i), 0, 1);
         end
      end

      // CTS held high in ISSUE: no ready, no start; release gives ready now, start next cycle.
      wait_idle("cts_idle");
      bus.uart_cts_n = 1'b1;
      base = st_cyc.size();
      fdb  = fd_cyc.size();
      r0   = rdy0_seen;
      q0.push_back({1'b1, 8'h3C});
      repeat (500) @(posedge clk);
      #1;
      chk("cts_no_ready", rdy0_seen - r0, 0);
      chk("cts_no_start", st_cyc.size() - base, 0);
      chk("cts_grant_held", bus.grant, 2'b01);
      bus.uart_cts_n = 1'b0;
      @(negedge clk);
      chk("cts_ready_now", bus.req0_ready, 1'b1);
      @(negedge clk);
      chk("cts_start_next", bus.tx_start, 1'b1);
      chk("cts_tx_data", bus.tx_data, 8'h3C);
      s = cyc;
      repeat (2) @(posedge clk);
      #1 bus.uart_cts_n = 1'b1;
      for (int k = 0; k < 100 && fd_cyc.size() == fdb; k++) @(posedge clk);
      #1;
      chk("cts_byte_completes", (fd_cyc.size() > fdb) ? fd_cyc[fdb] - s : -1, D_FRAME_END);
      bus.uart_cts_n = 1'b0;

      // Owner stall: req0 drops valid mid-frame, req1 must wait for req0's last byte.
      wait_idle("stall_idle");
      base = st_cyc.size();
      q0.push_back({1'b0, 8'h44});
      q0.push_back({1'b1, 8'h55});
      wait_starts(base + 1, "stall_first_start");
      hold0 = 1'b1;
      r1 = rdy1_seen;
      q1.push_back({1'b1, 8'h66});
      repeat (60) @(posedge clk);
      #1;
      chk("stall_grant_locked", bus.grant, 2'b01);
      chk("stall_no_req1_ready", rdy1_seen - r1, 0);
      chk("stall_no_start", st_cyc.size() - base, 1);
      hold0 = 1'b0;
      wait_starts(base + 3, "stall_resume");
      if (st_cyc.size() >= base + 3) begin
         chk("stall_owner_byte", {st_gnt[base + 1], st_dat[base + 1]}, {2'b01, 8'h55});
         chk("stall_next_frame", {st_gnt[base + 2], st_dat[base + 2]}, {2'b10, 8'h66});
      end

      // Transmitter stuck busy.
      wait_idle("wdt_idle");
      stuck = 1'b1;
      base = st_cyc.size();
      fdb  = fd_cyc.size();
      q0.push_back({1'b1, 8'h99});
      wait_starts(base + 1, "wdt_start");
      s = (st_cyc.size() > base) ? st_cyc[base] : 0;
`ifdef UART_TX_FRAME_ARBITER_WDT_EN
      for (int k = 0; k < WDT + 20 && wdt_cyc.size() == 0; k++) @(posedge clk);
      #1;
      chk("wdt_pulse_time", (wdt_cyc.size() > 0) ? wdt_cyc[0] - s : -1, WDT);
      chk("wdt_single_pulse", wdt_cyc.size(), 1);
      chk("wdt_grant_cleared", bus.grant, 2'b00);
      chk("wdt_no_frame_done", fd_cyc.size() - fdb, 0);
`else
      repeat (WDT + 20) @(posedge clk);
      #1;
      chk("nowdt_no_pulse", wdt_cyc.size(), 0);
      chk("nowdt_grant_held", bus.grant, 2'b01);
      chk("nowdt_no_frame_done", fd_cyc.size() - fdb, 0);
`endif
      stuck = 1'b0;

      // Reset in the middle of a byte, then a tie that req0 must win.
      wait_idle("rstmid_idle");
      base = st_cyc.size();
      q1.push_back({1'b1, 8'hAB});
      wait_starts(base + 1, "rstmid_start");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_grant", bus.grant, 2'b00);
      chk("rstmid_tx_start", bus.tx_start, 1'b0);
      chk("rstmid_tx_data", bus.tx_data, 8'h00);
      chk("rstmid_flags", {bus.frame_done, bus.wdt_error, bus.req0_ready, bus.req1_ready}, 4'b0000);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      base = st_cyc.size();
      q0.push_back({1'b1, 8'hD1});
      q1.push_back({1'b1, 8'hD2});
      wait_starts(base + 2, "rstmid_tie");
      if (st_cyc.size() >= base + 2) begin
         chk("rstmid_req0_wins", {st_gnt[base], st_dat[base]}, {2'b01, 8'hD1});
         chk("rstmid_req1_next", {st_gnt[base + 1], st_dat[base + 1]}, {2'b10, 8'hD2});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/uart_tx_frame_arbiter.md
# uart_tx_frame_arbiter

Controller that shares one UART byte transmitter between two frame-oriented requesters, e.g. a command-response path and an asynchronous event path. It grants whole frames in round-robin order and sequences each byte into the transmitter via a start/busy handshake. It enforces programmable inter-byte and inter-frame gaps, gates new bytes on CTS, and optionally aborts a frame when the transmitter stalls. It sits between the frame builders and the UART TX serializer.

## Interface
Parameters:
- BYTE_GAP_CYCLES, 100, idle clocks inserted after each non-last byte completes (0 = none)
- FRAME_GAP_CYCLES, 1000, idle clocks inserted after the last byte of a frame (0 = none)
- WDT_CYCLES, 17360, max clocks from tx_start to tx_busy falling (about 1.6 byte times at 125 MHz / 115200); used only with the watchdog compiled in

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has a byte
- req0_data / req1_data  in  8  byte to send
- req0_last / req1_last  in  1  byte is the last of its frame
- req0_ready / req1_ready  out  1  byte accepted this cycle
- uart_cts_n  in  1  low = peer may receive
- tx_start  out  1  one-cycle pulse; transmitter loads tx_data
- tx_data  out  8  registered byte to transmit
- tx_busy  in  1  transmitter is shifting a byte
- grant  out  2  one-hot frame owner; 0 when idle
- frame_done  out  1  one-cycle pulse when a frame's gap completes
- wdt_error  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, BYTE_GAP, FRAME_GAP.
- IDLE:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester not served last. After reset, req0 wins.
  - Go to ISSUE.
- ISSUE:
  - When owner valid=1 and uart_cts_n=0: owner ready=1 (combinational, this cycle only).
  - Capture data into tx_data and data/last into last_flag. Go to WAIT_BUSY.
  - The frame is locked: a non-owner is never served mid-frame, even if the owner's valid stays low indefinitely.
- WAIT_BUSY: tx_start is high on the first cycle only. Wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0. If last_flag=1, go to FRAME_GAP; otherwise go to BYTE_GAP.
- BYTE_GAP: count BYTE_GAP_CYCLES, then go to ISSUE. If the parameter is 0, go straight from WAIT_DONE to ISSUE.
- FRAME_GAP:
  - Count FRAME_GAP_CYCLES.
  - On the final cycle, pulse frame_done, record last-served = owner, clear grant, go to IDLE.
  - If the parameter is 0, this all happens on the cycle WAIT_DONE sees tx_busy=0.
- CTS is sampled only in ISSUE. A byte already started always completes.
- Gap counter: one shared down-counter, width $clog2(max(BYTE_GAP_CYCLES, FRAME_GAP_CYCLES, WDT_CYCLES)+1). Loaded on state entry; saturates at 0.
- Reset values: grant=0, tx_start=0, tx_data=8'h00, frame_done=0, wdt_error=0, ready outputs=0, state=IDLE, last-served=req1.
- Reset asserted mid-frame drops to these values immediately. No partial frame resumes.

## Timing
- Cycle T: IDLE sees req0_valid=1.
- T+1: grant=01, ISSUE. If CTS is low: req0_ready=1 and data is captured.
- T+2: tx_start=1, tx_data valid. Accept-to-start latency is 1 cycle.
- Byte-to-byte spacing after tx_busy falls, non-last byte: fall cycle, then BYTE_GAP_CYCLES, then ISSUE. The next ready comes BYTE_GAP_CYCLES+1 cycles after the first tx_busy=0 cycle.
- Frame turnaround: frame_done pulses on the last FRAME_GAP cycle. The next grant appears 2 cycles later (IDLE, then registered grant).
- Simultaneous valid in IDLE on the same cycle as frame_done is not possible: frame_done exits to IDLE.

## Configuration
- Macro: UART_TX_FRAME_ARBITER_WDT_EN.
- Defined:
  - A watchdog counter runs in WAIT_BUSY and WAIT_DONE, loaded with WDT_CYCLES at tx_start.
  - On reaching 0: pulse wdt_error, clear grant, set last-served = owner, go to IDLE. frame_done is not pulsed.
  - The requester's remaining bytes are arbitrated as a new frame.
- Undefined: no watchdog logic; wdt_error is tied to 0; WAIT states wait indefinitely.

## Test plan
- Single frame: req0 sends 3 bytes A5, 5A, FF (last on FF). The transmitter model holds busy for 10850 cycles. Expect 3 tx_start pulses with the data in order, 100-cycle byte gaps, frame_done after 1000 gap cycles, and grant returning to 0.
- Contention: both valid in the same IDLE cycle after reset. Expect req0 to win. req1's frame 12,34 (last) follows only after req0's frame_done. A second tie then goes to the opposite requester.
- CTS gating: uart_cts_n=1 while in ISSUE for 500 cycles. Expect no ready and no tx_start. Dropping CTS gives ready on that cycle and tx_start on the next. Raising CTS mid-byte does not cut the byte short.
- Owner stall: req0 drops valid mid-frame while req1 is valid. Expect grant to stay 01 and req1_ready to stay 0 until req0 completes its last byte.
- Watchdog (macro defined): tx_busy held high forever. Expect wdt_error pulse exactly WDT_CYCLES=17360 cycles after tx_start, grant=0, and no frame_done. Without the macro, expect no pulse and the block stuck in WAIT_DONE.
- Reset mid-byte: deassert rst_n during WAIT_DONE. Expect all outputs at their reset values immediately, with req0 winning the next arbitration.
